// File: rtl/imem_fetch_unit.sv
// Synchronous instruction memory with a valid/ready fetch port, a run-time
// program-load write port and a NOP-fill sequencer that runs after reset.
// Misaligned or out-of-range fetches come back as faults instead of aliasing.
`timescale 1ns/1ps
module imem_fetch_unit #(
    parameter int unsigned DEPTH     = 256,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
    parameter int unsigned IDX_W     = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [31:0]      req_addr,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_instr,
    output logic             rsp_fault,
    input  logic             prog_we,
    input  logic [IDX_W-1:0] prog_idx,
    input  logic [31:0]      prog_data,
    output logic             init_done
);

    typedef enum logic {S_INIT, S_RUN} state_t;

    // Address window in 33 bits so BASE_ADDR + DEPTH*4 cannot wrap.
    localparam logic [32:0] LO_X = {1'b0, BASE_ADDR};
    localparam logic [32:0] HI_X = LO_X + 33'(DEPTH) * 33'd4;

    state_t           state, state_nxt;
    logic [IDX_W-1:0] cnt;
    logic             last_fill;
    logic [31:0]      mem [DEPTH];

    logic             accept;
    logic [32:0]      addr_x;
    logic             misaligned, out_of_range, fault;
    logic [31:0]      offset;
    logic [IDX_W-1:0] rd_idx;

    assign last_fill    = (cnt == IDX_W'(DEPTH - 1));
    assign accept       = req_valid && req_ready;
    assign addr_x       = {1'b0, req_addr};
    assign misaligned   = |req_addr[1:0];
    assign out_of_range = (addr_x < LO_X) || (addr_x >= HI_X);
    assign fault        = misaligned || out_of_range;
    assign offset       = req_addr - BASE_ADDR;
    assign rd_idx       = IDX_W'(offset >> 2);

    // State register: reset always returns to the fill sequence.
    always_ff @(posedge clk) begin
        if (rst) state <= S_INIT;
        else     state <= state_nxt;
    end

    // Next state: leave INIT on the edge that fills the last word.
    always_comb begin
        state_nxt = state;
        if (state == S_INIT && last_fill) state_nxt = S_RUN;
    end

    // Outputs: fetches only accepted in RUN with a free or draining output slot.
    always_comb begin
        init_done = (state == S_RUN);
        req_ready = (state == S_RUN) && (!rsp_valid || rsp_ready);
    end

    // Fill counter walks every word once during INIT.
    always_ff @(posedge clk) begin
        if (rst)                  cnt <= '0;
        else if (state == S_INIT) cnt <= cnt + 1'b1;
    end

    // Single write port: fill takes priority, program loads are dropped in INIT.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == S_INIT) mem[cnt]      <= NOP_INSTR;
            else if (prog_we)    mem[prog_idx] <= prog_data;
        end
    end

    // Registered read; reading before the same-edge write yields the old word.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_fault <= 1'b0;
            rsp_instr <= NOP_INSTR;
        end else if (accept) begin
            rsp_valid <= 1'b1;
            rsp_fault <= fault;
            rsp_instr <= fault ? NOP_INSTR : mem[rd_idx];
        end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

endmodule

// File: doc/imem_fetch_unit.md
Name: imem_fetch_unit

Overview:
Parametrised synchronous instruction memory with a valid/ready fetch port, a program-load write port and a power-up NOP-fill sequencer. It replaces the combinational instruction ROM in the fetch path. It allows programs to be loaded at run time and tolerates a stalled consumer. Fetches that are misaligned or out of range are reported as faults, not silently aliased.

Parameters:
DEPTH, 256, number of 32-bit words; must be a power of 2, minimum 4
BASE_ADDR, 32'h0000_0000, byte address of word 0; must be DEPTH*4-aligned
NOP_INSTR, 32'h0000_0013, fill and fault-return value (addi x0,x0,0)
IDX_W, $clog2(DEPTH), word-index width (derived, not overridden)

Ports:
clk  in  1  sole clock; all state updates on the rising edge
rst  in  1  synchronous, active-high reset
req_valid  in  1  fetch request valid
req_ready  out  1  unit can accept a fetch this cycle
req_addr  in  32  fetch byte address
rsp_valid  out  1  response valid
rsp_ready  in  1  consumer accepts the response
rsp_instr  out  32  fetched instruction
rsp_fault  out  1  response is a fault (misaligned or out of range)
prog_we  in  1  program-load write strobe
prog_idx  in  IDX_W  word index to write
prog_data  in  32  word to write
init_done  out  1  NOP fill complete; unit operational

Behaviour:
- States: INIT, RUN. rst=1 at an edge -> state=INIT, fill counter=0, rsp_valid=0, rsp_fault=0, rsp_instr=NOP_INSTR, init_done=0. rst overrides all other inputs.
- INIT: each edge writes mem[cnt]=NOP_INSTR and increments cnt. The edge that writes index DEPTH-1 moves the state to RUN. init_done=1 exactly DEPTH edges after the first edge with rst=0. During INIT, req_ready=0 and prog_we is ignored (dropped, not queued).
- RUN: init_done=1. req_ready = !rsp_valid || rsp_ready (single output register; full throughput, one fetch per cycle).
- Accept = req_valid && req_ready. On the accepting edge, rsp_valid becomes 1 and the response is driven from the next cycle. Latency is 1 cycle.
- Fault check on accept:
  - misaligned if req_addr[1:0]!=0.
  - out of range if req_addr<BASE_ADDR or req_addr>=BASE_ADDR+DEPTH*4. Compute in 33-bit arithmetic; no wrap.
  - On fault: rsp_fault=1, rsp_instr=NOP_INSTR, and memory is not read.
  - Otherwise: rsp_fault=0, rsp_instr=mem[(req_addr-BASE_ADDR)>>2].
- Response hold: while rsp_valid && !rsp_ready, rsp_instr and rsp_fault stay stable and no new request is accepted.
- Response drain: rsp_valid && rsp_ready with no new accept -> rsp_valid=0 on that edge. If a new accept occurs on the same edge, rsp_valid stays 1 with the new data.
- prog_we in RUN: mem[prog_idx]=prog_data on the edge. Writes are independent of the fetch handshake and never stall it.
- Same-edge write and fetch of the same word: the response returns the OLD word (read-before-write). A fetch on the next edge returns the new word.
- Reset mid-operation: any outstanding response is discarded (rsp_valid=0 after the reset edge). INIT reruns and all previously loaded content is overwritten with NOP_INSTR.
- Memory must infer as a synchronous-read RAM. No combinational path from req_addr to rsp_instr.

Test Plan:
1. Reset fill (DEPTH=256): hold rst 2 cycles, release -> init_done=0 and req_ready=0 for 256 edges, then 1; fetch 0x0, 0x3FC -> rsp_instr=0x00000013, rsp_fault=0.
2. Load and stream: write idx0..8 = 00000093, 00A00113, 0020A023, 0000A183, 00310463, 00118193, 008000EF, 00120213, 00500293; fetch 0x00..0x20 back-to-back with rsp_ready=1 -> 9 consecutive responses, one per cycle, in order, starting 1 cycle after first accept; addr 0x04 -> 0x00A00113.
3. Backpressure: hold rsp_ready=0 for 3 cycles with a pending response for 0x10 -> req_ready=0 and rsp_instr stable at 0x00310463; release -> next request accepted on the same edge the response drains.
4. Faults: fetch 0x402 -> rsp_fault=1, rsp_instr=0x00000013; fetch 0x400 -> rsp_fault=1; with BASE_ADDR=0x1000, fetch 0x0FFC -> fault and fetch 0x1004 -> mem[1]; fetch 0xFFFF_FFFC -> fault, no wrap.
5. Write/read collision: prog_we idx=2 data=0xDEADBEEF on the same edge as fetch of 0x08 -> response 0x0020A023; refetch -> 0xDEADBEEF.
6. Reset mid-stream: assert rst while rsp_valid=1 -> rsp_valid=0 after the edge; after init_done, fetch 0x04 -> 0x00000013; prog_we during INIT has no effect.
